// File: rtl/flap_event_gen.sv
`default_nettype none
// ============================================================================
//  Module   : flap_event_gen
//  Purpose  : Debounces the synchronized player button level and produces
//             clean press / release pulses, a held level, optional
//             hold-to-repeat presses and a saturating press counter.
//  Revision : 1.0 - initial release
// ============================================================================
module flap_event_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic       enable,
  input  logic       clear_count,
  output logic       press,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  // Counter widths only need to reach (parameter - 1).
  localparam int C_DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int C_RW   = (C_RMAX > 1) ? $clog2(C_RMAX) : 1;

  localparam logic [C_DW-1:0] C_DLAST   = C_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_DW-1:0] C_DONE    = C_DW'(1);
  localparam logic [C_RW-1:0] C_RDLAST  = C_RW'(REPEAT_DELAY - 1);
  localparam logic [C_RW-1:0] C_RRLAST  = C_RW'(REPEAT_RATE - 1);
  localparam logic [7:0]      C_CNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DEB_PRESS   = 3'd1,
    S_HELD        = 3'd2,
    S_REPEAT      = 3'd3,
    S_DEB_RELEASE = 3'd4
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [C_DW-1:0] r_dcnt,    w_dcnt_nxt;
  logic [C_RW-1:0] r_rcnt,    w_rcnt_nxt;
  logic            r_press,   w_press_nxt;
  logic            r_release, w_release_nxt;
  logic            r_held,    w_held_nxt;
  logic [7:0]      r_press_count;

  // State, counters and all outputs are registered; reset acts immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dcnt    <= '0;
      r_rcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_held    <= w_held_nxt;
    end
  end

  // Next-state, counter and pulse decode; disable forces everything idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_rcnt_nxt    = r_rcnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_held_nxt    = r_held;

    case (r_state)
      S_IDLE: begin
        w_held_nxt = 1'b0;
        w_dcnt_nxt = '0;
        w_rcnt_nxt = '0;
        if (level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = S_HELD;
            w_press_nxt = 1'b1;
            w_held_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DEB_PRESS;
            w_dcnt_nxt  = C_DONE;
          end
        end
      end

      S_DEB_PRESS: begin
        w_held_nxt = 1'b0;
        if (!level) begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == C_DLAST) begin
          w_state_nxt = S_HELD;
          w_press_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_dcnt_nxt  = '0;
          w_rcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end

      S_HELD, S_REPEAT: begin
        w_held_nxt = 1'b1;
        if (!level) begin
          // Single-sample debounce releases without a confirmation phase.
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt   = S_IDLE;
            w_release_nxt = 1'b1;
            w_held_nxt    = 1'b0;
            w_dcnt_nxt    = '0;
          end else begin
            w_state_nxt = S_DEB_RELEASE;
            w_dcnt_nxt  = C_DONE;
          end
          w_rcnt_nxt = '0;
        end else if (r_state == S_HELD) begin
          if ((REPEAT_EN != 0) && (r_rcnt == C_RDLAST)) begin
            w_state_nxt = S_REPEAT;
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end else begin
          if (r_rcnt == C_RRLAST) begin
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end

      S_DEB_RELEASE: begin
        w_held_nxt = 1'b1;
        if (level) begin
          // A bounce back high restarts the repeat delay from scratch.
          w_state_nxt = S_HELD;
          w_dcnt_nxt  = '0;
          w_rcnt_nxt  = '0;
        end else if (r_dcnt == C_DLAST) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
          w_dcnt_nxt    = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_dcnt_nxt  = '0;
        w_rcnt_nxt  = '0;
        w_held_nxt  = 1'b0;
      end
    endcase

    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_dcnt_nxt    = '0;
      w_rcnt_nxt    = '0;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_held_nxt    = 1'b0;
    end
  end

  // Saturating press counter, counted in step with the press pulse; clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press_count <= 8'd0;
    end else if (clear_count) begin
      r_press_count <= 8'd0;
    end else if (w_press_nxt && (r_press_count != C_CNT_MAX)) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign press         = r_press;
  assign release_pulse = r_release;
  assign held          = r_held;
  assign press_count   = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_flap_event_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_flap_event_gen
//  Purpose  : Self-checking bench for flap_event_gen (debounce 4, repeat
//             delay 8, repeat rate 3) using a cycle table and a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flap_event_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       level = 1'b0;
  logic       enable = 1'b0;
  logic       clear_count = 1'b0;
  logic       press;
  logic       release_pulse;
  logic       held;
  logic [7:0] press_count;

  typedef struct packed {
    logic       press;
    logic       rel;
    logic       held;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic level;
    logic enable;
    logic clear;
    int   reps;
    exp_t exp;
    string name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  flap_event_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level        (level),
    .enable       (enable),
    .clear_count  (clear_count),
    .press        (press),
    .release_pulse(release_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  function automatic exp_t mk(input logic p, input logic r, input logic h, input int c);
    exp_t e;
    e.press = p;
    e.rel   = r;
    e.held  = h;
    e.cnt   = 8'(c);
    return e;
  endfunction

  task automatic add(input logic lv, input logic en, input logic clr, input int reps,
                     input logic p, input logic r, input logic h, input int c,
                     input string name);
    vec_t v;
    v.level  = lv;
    v.enable = en;
    v.clear  = clr;
    v.reps   = reps;
    v.exp    = mk(p, r, h, c);
    v.name   = name;
    tbl.push_back(v);
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs now.
  task automatic check_now(input string name);
    exp_t e;
    exp_t a;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
      return;
    end
    e = sb_q.pop_front();
    a = {press, release_pulse, held, press_count};
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got press=%b rel=%b held=%b cnt=%0d, expected press=%b rel=%b held=%b cnt=%0d",
               name, $time, a.press, a.rel, a.held, a.cnt, e.press, e.rel, e.held, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue its expected result, check after the edge.
  task automatic step(input logic lv, input logic en, input logic clr, input exp_t e,
                      input string name);
    level       = lv;
    enable      = en;
    clear_count = clr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_now(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_m;
    logic p;

    // Long hold with auto-repeat, then a clean release.
    add(1,1,0, 3, 0,0,0,0, "t1_debounce");
    add(1,1,0, 1, 1,0,1,1, "t1_press");
    add(1,1,0, 7, 0,0,1,1, "t1_held");
    add(1,1,0, 1, 1,0,1,2, "t1_rep_first");
    add(1,1,0, 2, 0,0,1,2, "t1_rep_gap");
    add(1,1,0, 1, 1,0,1,3, "t1_rep_2");
    add(1,1,0, 2, 0,0,1,3, "t1_rep_gap");
    add(1,1,0, 1, 1,0,1,4, "t1_rep_3");
    add(1,1,0, 2, 0,0,1,4, "t1_rep_gap");
    add(0,1,0, 3, 0,0,1,4, "t1_deb_rel");
    add(0,1,0, 1, 0,1,0,4, "t1_release");
    add(0,1,0, 2, 0,0,0,4, "t1_idle");
    // Glitch of three highs is rejected, then four highs press.
    add(1,1,0, 3, 0,0,0,4, "t2_glitch");
    add(0,1,0, 1, 0,0,0,4, "t2_glitch_drop");
    add(1,1,0, 3, 0,0,0,4, "t2_debounce");
    add(1,1,0, 1, 1,0,1,5, "t2_press");
    // Release bounce: low 2, high 1, low 4.
    add(0,1,0, 2, 0,0,1,5, "t3_low2");
    add(1,1,0, 1, 0,0,1,5, "t3_bounce");
    add(0,1,0, 3, 0,0,1,5, "t3_deb_rel");
    add(0,1,0, 1, 0,1,0,5, "t3_release");
    add(0,1,0, 2, 0,0,0,5, "t3_idle");
    // Counter clear, and disable blocks a press while idle.
    add(0,1,1, 1, 0,0,0,0, "clear");
    add(1,0,0, 2, 0,0,0,0, "disabled_idle");
    // Disable while held, then re-enable with level high.
    add(1,1,0, 3, 0,0,0,0, "t5_debounce");
    add(1,1,0, 1, 1,0,1,1, "t5_press");
    add(1,1,0, 2, 0,0,1,1, "t5_held");
    add(1,0,0, 1, 0,0,0,1, "t5_disable");
    add(1,0,0, 2, 0,0,0,1, "t5_disabled");
    add(1,1,0, 3, 0,0,0,1, "t5_reenable_deb");
    add(1,1,0, 1, 1,0,1,2, "t5_reenable_press");
    add(0,1,0, 3, 0,0,1,2, "t5_deb_rel");
    add(0,1,0, 1, 0,1,0,2, "t5_release");
    add(0,1,0, 1, 0,0,0,2, "t5_idle");

    // Reset state, checked between edges while reset is held low.
    #12;
    sb_q.push_back(mk(0,0,0,0));
    check_now("reset_state");
    reset = 1'b1;
    enable = 1'b1;

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].reps; r++) begin
        step(tbl[k].level, tbl[k].enable, tbl[k].clear, tbl[k].exp, tbl[k].name);
      end
    end

    // Asynchronous reset in the middle of a press debounce.
    step(1,1,0, mk(0,0,0,2), "t4_deb");
    step(1,1,0, mk(0,0,0,2), "t4_deb");
    #3;
    reset = 1'b0;
    #1;
    sb_q.push_back(mk(0,0,0,0));
    check_now("t4_async_reset");
    @(posedge clk);
    #1;
    sb_q.push_back(mk(0,0,0,0));
    check_now("t4_reset_held");
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1,1,0, mk(0,0,0,0), "t4_post_reset_deb");
    step(1,1,0, mk(1,0,1,1), "t4_post_reset_press");
    for (int i = 0; i < 3; i++) step(0,1,0, mk(0,0,1,1), "t4_deb_rel");
    step(0,1,0, mk(0,1,0,1), "t4_release");

    // Long hold: press count saturates, then clear coincides with a press.
    step(0,1,1, mk(0,0,0,0), "t6_clear");
    cnt_m = 0;
    for (int i = 0; i < 787; i++) begin
      p = (i == 3) || (i == 11) || ((i > 11) && (((i - 11) % 3) == 0));
      if (i == 782) cnt_m = 0;
      else if (p && (cnt_m < 255)) cnt_m++;
      step(1,1,(i == 782), mk(p, 1'b0, (i >= 3), cnt_m), "t6_hold_repeat");
    end
    for (int i = 0; i < 3; i++) step(0,1,0, mk(0,0,1,1), "t6_deb_rel");
    step(0,1,0, mk(0,1,0,1), "t6_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
